// File: rtl/ps2_kbd_decoder.sv
// rtl/ps2_kbd_decoder.sv - PS/2 scan-code set 2 decoder with FWFT key-event FIFO
module ps2_kbd_decoder #(
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_ack,
    input  logic               rx_err,
    input  logic [7:0]         rx_data,
    input  logic               pop,
    input  logic               clr,
    output logic               event_valid,
    output logic [7:0]         event_code,
    output logic               event_ext,
    output logic               event_break,
    output logic [FIFO_AW:0]   count,
    output logic [7:0]         resp,
    output logic               resp_valid,
    output logic               overflow,
    output logic               err
);

    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EXT    = 3'd1,
        BRK    = 3'd2,
        EXTBRK = 3'd3,
        PAUSE  = 3'd4
    } state_t;

    state_t       state, state_nxt;
    logic [2:0]   skip_cnt, skip_nxt;

    logic         push;
    logic [9:0]   push_data;
    logic         resp_load;

    logic [9:0]         mem [DEPTH];
    logic [FIFO_AW:0]   wr_ptr, rd_ptr;
    logic               fifo_full, fifo_empty;
    logic               do_push, do_pop;
    logic [9:0]         head;

    function automatic logic is_resp(input logic [7:0] b);
        return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFE) ||
               (b == 8'hFC) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == 8'h12) || (b == 8'h59);
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            skip_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
        end
    end

    // Next-state logic; rx_err overrides any byte arriving in the same cycle
    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        if (rx_err) begin
            state_nxt = IDLE;
            skip_nxt  = 3'd0;
        end else if (rx_ack) begin
            unique case (state)
                IDLE: begin
                    if (rx_data == 8'hE0) begin
                        state_nxt = EXT;
                    end else if (rx_data == 8'hF0) begin
                        state_nxt = BRK;
                    end else if (rx_data == 8'hE1) begin
                        state_nxt = PAUSE;
                        skip_nxt  = 3'd0;
                    end
                end
                EXT:    state_nxt = (rx_data == 8'hF0) ? EXTBRK : IDLE;
                BRK:    state_nxt = IDLE;
                EXTBRK: state_nxt = IDLE;
                PAUSE: begin
                    if (skip_cnt == 3'd6) begin
                        state_nxt = IDLE;
                        skip_nxt  = 3'd0;
                    end else begin
                        skip_nxt = skip_cnt + 3'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output decode: event push and response capture; entry = {ext, brk, code}
    always_comb begin
        push      = 1'b0;
        push_data = 10'd0;
        resp_load = 1'b0;
        if (rx_ack && !rx_err) begin
            unique case (state)
                IDLE: begin
                    if (is_resp(rx_data)) begin
                        resp_load = 1'b1;
                    end else if (rx_data != 8'hE0 && rx_data != 8'hF0 && rx_data != 8'hE1) begin
                        push      = 1'b1;
                        push_data = {1'b0, 1'b0, rx_data};
                    end
                end
                EXT: begin
                    if (rx_data != 8'hF0 && !is_fake_shift(rx_data)) begin
                        push      = 1'b1;
                        push_data = {1'b1, 1'b0, rx_data};
                    end
                end
                BRK: begin
                    push      = 1'b1;
                    push_data = {1'b0, 1'b1, rx_data};
                end
                EXTBRK: begin
                    if (!is_fake_shift(rx_data)) begin
                        push      = 1'b1;
                        push_data = {1'b1, 1'b1, rx_data};
                    end
                end
                PAUSE: begin
                    if (skip_cnt == 3'd6) begin
                        push      = 1'b1;
                        push_data = {1'b1, 1'b0, 8'h77};
                    end
                end
                default: ;
            endcase
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (count == DEPTH[FIFO_AW:0]);
    assign do_pop     = pop && !fifo_empty;
    assign do_push    = push && (!fifo_full || do_pop);
    assign count      = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            resp       <= 8'd0;
            resp_valid <= 1'b0;
            overflow   <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            resp_valid <= resp_load;
            if (resp_load) resp <= rx_data;
            // Set conditions take priority over clr
            if (push && !do_push)  overflow <= 1'b1;
            else if (clr)          overflow <= 1'b0;
            if (rx_err)            err <= 1'b1;
            else if (clr)          err <= 1'b0;
        end
    end

    // Storage is not reset, so head fields are masked while empty
    assign head        = fifo_empty ? 10'd0 : mem[rd_ptr[FIFO_AW-1:0]];
    assign event_valid = !fifo_empty;
    assign event_code  = head[7:0];
    assign event_break = head[8];
    assign event_ext   = head[9];

endmodule
